// File: rtl/ghost_mover_if.sv
// Handshake/bus bundle between a ghost_mover instance and its surroundings:
// per-frame controls and wall flags in, sprite position and state out.
interface ghost_mover_if #(
    parameter int WALL_W = 5
);
    logic              frame_tick;
    logic              restart;
    logic              life_down;
    logic              frighten;
    logic              eaten;
    logic [7:0]        keycode;
    logic [WALL_W-1:0] mapL;
    logic [WALL_W-1:0] mapR;
    logic [WALL_W-1:0] mapB;
    logic [WALL_W-1:0] mapT;
    logic [9:0]        ghostX;
    logic [9:0]        ghostY;
    logic [9:0]        ghostS;
    logic [1:0]        dir;
    logic              moving;
    logic [1:0]        mode;
    logic              visible;

    modport master (
        output frame_tick, restart, life_down, frighten, eaten, keycode,
               mapL, mapR, mapB, mapT,
        input  ghostX, ghostY, ghostS, dir, moving, mode, visible
    );

    modport slave (
        input  frame_tick, restart, life_down, frighten, eaten, keycode,
               mapL, mapR, mapB, mapT,
        output ghostX, ghostY, ghostS, dir, moving, mode, visible
    );
endinterface

// File: rtl/ghost_mover.sv
// Ghost movement engine: mode FSM (home/roam/frightened/eaten), wall-aware steering and tunnel wrap.
// Optional GHOST_REVERSE_EN: heading flips when a roaming ghost becomes frightened.
module ghost_mover #(
    parameter int X_CENTER    = 142,
    parameter int Y_CENTER    = 166,
    parameter int X_MIN       = 7,
    parameter int X_MAX       = 396,
    parameter int Y_MIN       = 7,
    parameter int Y_MAX       = 440,
    parameter int SIZE        = 13,
    parameter int STEP        = 1,
    parameter int WALL_W      = 5,
    parameter int RELEASE_FRM = 60,
    parameter int FRIGHT_FRM  = 360,
    parameter int EATEN_FRM   = 120,
    parameter int TUN_Y_LO    = 195,
    parameter int TUN_Y_HI    = 223,
    parameter int WRAP_L      = 10,
    parameter int WRAP_R      = 390,
    parameter int DEST_L      = 15,
    parameter int DEST_R      = 385
) (
    input logic          Clk,
    input logic          Reset_n,
    ghost_mover_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_HOME   = 2'd0,
        MODE_ROAM   = 2'd1,
        MODE_FRIGHT = 2'd2,
        MODE_EATEN  = 2'd3
    } mode_t;

    localparam logic [1:0]  DIR_L = 2'd0;
    localparam logic [1:0]  DIR_R = 2'd1;
    localparam logic [1:0]  DIR_D = 2'd2;
    localparam logic [1:0]  DIR_U = 2'd3;

    localparam logic [9:0]  X_CENTER_C  = 10'(X_CENTER);
    localparam logic [9:0]  Y_CENTER_C  = 10'(Y_CENTER);
    localparam logic [9:0]  SIZE_C      = 10'(SIZE);
    localparam logic [9:0]  STEP_C      = 10'(STEP);
    localparam logic [10:0] SIZE_W_C    = 11'(SIZE);
    localparam logic [10:0] L_LIM_C     = 11'(X_MIN + SIZE);
    localparam logic [10:0] R_LIM_C     = 11'(X_MAX);
    localparam logic [10:0] T_LIM_C     = 11'(Y_MIN + SIZE);
    localparam logic [10:0] B_LIM_C     = 11'(Y_MAX);
    localparam logic [9:0]  TUN_Y_LO_C  = 10'(TUN_Y_LO);
    localparam logic [9:0]  TUN_Y_HI_C  = 10'(TUN_Y_HI);
    localparam logic [9:0]  WRAP_L_C    = 10'(WRAP_L);
    localparam logic [9:0]  WRAP_R_C    = 10'(WRAP_R);
    localparam logic [9:0]  DEST_L_C    = 10'(DEST_L);
    localparam logic [9:0]  DEST_R_C    = 10'(DEST_R);
    localparam logic [9:0]  REL_LAST_C  = 10'(RELEASE_FRM - 1);
    localparam logic [9:0]  FR_LAST_C   = 10'(FRIGHT_FRM - 1);
    localparam logic [9:0]  EAT_LAST_C  = 10'(EATEN_FRM - 1);

    logic [9:0] x_r;
    logic [9:0] y_r;
    logic [1:0] dir_r;
    logic       moving_r;
    mode_t      mode_r;
    logic       visible_r;
    logic [9:0] timer_r;
    logic       parity_r;

    logic       srst_s;
    logic       req_valid_s;
    logic [1:0] req_dir_s;
    logic       in_tunnel_s;
    logic [3:0] blocked_s;
    logic [1:0] new_dir_s;
    logic       new_moving_s;
    logic [9:0] step_x_s;
    logic [9:0] step_y_s;
    logic [9:0] next_x_s;
    logic [9:0] next_y_s;

    // Opposite heading: L<->R and D<->U differ only in the low bit.
    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        reverse_dir = {d[1], ~d[0]};
    endfunction

    assign srst_s = bus.restart | bus.life_down;

    // Decode the requested heading from the keycode.
    always_comb begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_L;
        case (bus.keycode)
            8'h04:   req_dir_s = DIR_L;
            8'h07:   req_dir_s = DIR_R;
            8'h16:   req_dir_s = DIR_D;
            8'h1A:   req_dir_s = DIR_U;
            default: req_valid_s = 1'b0;
        endcase
    end

    // Per-direction blocking; horizontal borders do not apply inside the tunnel
    // row so the ghost can run off the edge and wrap.
    always_comb begin
        in_tunnel_s  = (y_r >= TUN_Y_LO_C) && (y_r <= TUN_Y_HI_C);
        blocked_s[0] = (|bus.mapL) || (!in_tunnel_s && ({1'b0, x_r} <= L_LIM_C));
        blocked_s[1] = (|bus.mapR) || (!in_tunnel_s && (({1'b0, x_r} + SIZE_W_C) >= R_LIM_C));
        blocked_s[2] = (|bus.mapB) || (({1'b0, y_r} + SIZE_W_C) >= B_LIM_C);
        blocked_s[3] = (|bus.mapT) || ({1'b0, y_r} <= T_LIM_C);
    end

    // Heading choice and the resulting one-step position.
    always_comb begin
        if (req_valid_s && !blocked_s[req_dir_s]) begin
            new_dir_s = req_dir_s;
        end else begin
            new_dir_s = dir_r;
        end
        new_moving_s = !blocked_s[new_dir_s];
        step_x_s     = x_r;
        step_y_s     = y_r;
        if (new_moving_s) begin
            case (new_dir_s)
                DIR_L:   step_x_s = x_r - STEP_C;
                DIR_R:   step_x_s = x_r + STEP_C;
                DIR_D:   step_y_s = y_r + STEP_C;
                DIR_U:   step_y_s = y_r - STEP_C;
                default: step_x_s = x_r;
            endcase
        end else begin
            step_x_s = x_r;
        end
    end

    // Tunnel wrap applied to the stepped position.
    always_comb begin
        next_x_s = step_x_s;
        next_y_s = step_y_s;
        if ((step_y_s >= TUN_Y_LO_C) && (step_y_s <= TUN_Y_HI_C)) begin
            if (step_x_s <= WRAP_L_C) begin
                next_x_s = DEST_R_C;
            end else if (step_x_s >= WRAP_R_C) begin
                next_x_s = DEST_L_C;
            end else begin
                next_x_s = step_x_s;
            end
        end else begin
            next_x_s = step_x_s;
        end
    end

    // Mode FSM, timers and motion state; priority restart > eaten > frighten > tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_r       <= X_CENTER_C;
            y_r       <= Y_CENTER_C;
            dir_r     <= DIR_L;
            moving_r  <= 1'b0;
            mode_r    <= MODE_HOME;
            visible_r <= 1'b1;
            timer_r   <= 10'd0;
            parity_r  <= 1'b0;
        end else if (srst_s) begin
            x_r       <= X_CENTER_C;
            y_r       <= Y_CENTER_C;
            dir_r     <= DIR_L;
            moving_r  <= 1'b0;
            mode_r    <= MODE_HOME;
            visible_r <= 1'b1;
            timer_r   <= 10'd0;
            parity_r  <= 1'b0;
        end else if (bus.eaten && (mode_r == MODE_FRIGHT)) begin
            mode_r    <= MODE_EATEN;
            timer_r   <= 10'd0;
            visible_r <= 1'b0;
        end else if (bus.frighten && (mode_r == MODE_ROAM)) begin
            mode_r   <= MODE_FRIGHT;
            timer_r  <= 10'd0;
            parity_r <= 1'b0;
`ifdef GHOST_REVERSE_EN
            dir_r    <= reverse_dir(dir_r);
`else
            dir_r    <= dir_r;
`endif
        end else if (bus.frighten && (mode_r == MODE_FRIGHT)) begin
            timer_r <= 10'd0;
        end else if (bus.frame_tick) begin
            case (mode_r)
                MODE_HOME: begin
                    moving_r <= 1'b0;
                    if (timer_r == REL_LAST_C) begin
                        mode_r  <= MODE_ROAM;
                        timer_r <= 10'd0;
                    end else begin
                        timer_r <= timer_r + 10'd1;
                    end
                end
                MODE_ROAM: begin
                    dir_r    <= new_dir_s;
                    moving_r <= new_moving_s;
                    x_r      <= next_x_s;
                    y_r      <= next_y_s;
                end
                MODE_FRIGHT: begin
                    parity_r <= ~parity_r;
                    if (parity_r) begin
                        dir_r    <= new_dir_s;
                        moving_r <= new_moving_s;
                        x_r      <= next_x_s;
                        y_r      <= next_y_s;
                    end else begin
                        moving_r <= 1'b0;
                    end
                    if (timer_r == FR_LAST_C) begin
                        mode_r  <= MODE_ROAM;
                        timer_r <= 10'd0;
                    end else begin
                        timer_r <= timer_r + 10'd1;
                    end
                end
                MODE_EATEN: begin
                    moving_r <= 1'b0;
                    if (timer_r == EAT_LAST_C) begin
                        x_r       <= X_CENTER_C;
                        y_r       <= Y_CENTER_C;
                        visible_r <= 1'b1;
                        mode_r    <= MODE_HOME;
                        timer_r   <= 10'd0;
                    end else begin
                        timer_r <= timer_r + 10'd1;
                    end
                end
                default: begin
                    mode_r  <= MODE_HOME;
                    timer_r <= 10'd0;
                end
            endcase
        end
    end

    assign bus.ghostX  = x_r;
    assign bus.ghostY  = y_r;
    assign bus.ghostS  = SIZE_C;
    assign bus.dir     = dir_r;
    assign bus.moving  = moving_r;
    assign bus.mode    = mode_r;
    assign bus.visible = visible_r;

endmodule
